// File: rtl/sopc_dbus_xbar_if.sv
// Bus bundle between the CPU data port, the crossbar and its data slaves.
// The crossbar takes the "slave" modport; the CPU side (and any environment
// that models the CPU plus the slaves) takes the "master" modport.
//
// Handshake: the CPU asserts m_ce_i with a stable request. The crossbar accepts
// it in the first cycle that m_ce_i is high while it is idle. m_stall_o stays
// high until the single DONE cycle, in which m_data_o/m_err_o are valid and the
// CPU retires the request. On the slave side, s_ce_o[i] is held with stable
// s_* fields until that slave pulses s_ack_i[i] for one cycle.
interface sopc_dbus_xbar_if #(
    parameter int NUM_SLV = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic                        m_ce_i;
    logic                        m_we_i;
    logic [ADDR_W-1:0]           m_addr_i;
    logic [SEL_W-1:0]            m_sel_i;
    logic [DATA_W-1:0]           m_data_i;
    logic [DATA_W-1:0]           m_data_o;
    logic                        m_stall_o;
    logic                        m_err_o;
    logic [NUM_SLV-1:0]          s_ce_o;
    logic                        s_we_o;
    logic [ADDR_W-1:0]           s_addr_o;
    logic [SEL_W-1:0]            s_sel_o;
    logic [DATA_W-1:0]           s_data_o;
    logic [NUM_SLV*DATA_W-1:0]   s_data_i;
    logic [NUM_SLV-1:0]          s_ack_i;
    logic                        err_clr_i;
    logic                        err_int_o;
    logic [ADDR_W-1:0]           err_addr_o;

    modport slave (
        input  m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
        input  s_data_i, s_ack_i, err_clr_i,
        output m_data_o, m_stall_o, m_err_o,
        output s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
        output err_int_o, err_addr_o
    );

    modport master (
        output m_ce_i, m_we_i, m_addr_i, m_sel_i, m_data_i,
        output s_data_i, s_ack_i, err_clr_i,
        input  m_data_o, m_stall_o, m_err_o,
        input  s_ce_o, s_we_o, s_addr_o, s_sel_o, s_data_o,
        input  err_int_o, err_addr_o
    );
endinterface

// File: rtl/sopc_dbus_xbar.sv
// Data-side crossbar: decodes the CPU address to one slave window, runs a
// registered request/ack transfer with CPU stall, times out silent slaves and
// keeps a sticky bus-error interrupt with the failing address.
module sopc_dbus_xbar #(
    parameter int                      NUM_SLV  = 4,
    parameter int                      ADDR_W   = 32,
    parameter int                      DATA_W   = 32,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE =
        {32'h1000_0000, 32'h0800_0000, 32'h0400_0000, 32'h0000_0000},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK = {4{32'hFC00_0000}},
    parameter int                      TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    sopc_dbus_xbar_if.slave     bus,
    output logic [1:0]          dbg_state_o
);
    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_int_q, err_int_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              ack_sel;
    logic [DATA_W-1:0] rdata_sel;
    logic              set_err;
    logic [ADDR_W-1:0] set_addr;
    logic              run;

    // Address decode; scanning downward lets the lowest matching index win.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((bus.m_addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign ack_sel   = bus.s_ack_i[idx_q];
    assign rdata_sel = bus.s_data_i[int'(idx_q)*DATA_W +: DATA_W];

    // Next-state logic for the transfer FSM, timeout counter and sticky error.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        we_d     = we_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        wdata_d  = wdata_q;
        rdata_d  = '0;
        err_d    = err_q;
        cnt_d    = cnt_q;
        set_err  = 1'b0;
        set_addr = '0;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (bus.m_ce_i) begin
                    if (hit) begin
                        idx_d   = hit_idx;
                        we_d    = bus.m_we_i;
                        addr_d  = bus.m_addr_i;
                        sel_d   = bus.m_sel_i;
                        wdata_d = bus.m_data_i;
                        state_d = ST_ACCESS;
                    end else begin
                        err_d    = 1'b1;
                        set_err  = 1'b1;
                        set_addr = bus.m_addr_i;
                        state_d  = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                // An ack in the timeout cycle still counts as normal completion.
                if (ack_sel) begin
                    rdata_d = we_q ? '0 : rdata_sel;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    err_d    = 1'b1;
                    set_err  = 1'b1;
                    set_addr = addr_q;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                rdata_d = '0;
                err_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Setting the sticky error takes priority over a same-cycle clear.
        err_int_d  = set_err ? 1'b1 : (bus.err_clr_i ? 1'b0 : err_int_q);
        err_addr_d = set_err ? set_addr : err_addr_q;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sel_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            err_int_q  <= 1'b0;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
            err_int_q  <= err_int_d;
            err_addr_q <= err_addr_d;
        end
    end

    // Outputs are forced low while reset is held, even before the reset edge.
    assign run = ~rst;

    assign bus.m_stall_o  = run & (((state_q == ST_IDLE) & bus.m_ce_i) | (state_q == ST_ACCESS));
    assign bus.m_data_o   = run ? rdata_q : '0;
    assign bus.m_err_o    = run & (state_q == ST_DONE) & err_q;
    assign bus.s_ce_o     = (run && state_q == ST_ACCESS) ? (NUM_SLV'(1) << idx_q) : '0;
    assign bus.s_we_o     = run & we_q;
    assign bus.s_addr_o   = run ? addr_q : '0;
    assign bus.s_sel_o    = run ? sel_q : '0;
    assign bus.s_data_o   = run ? wdata_q : '0;
    assign bus.err_int_o  = run & err_int_q;
    assign bus.err_addr_o = run ? err_addr_q : '0;
    assign dbg_state_o    = run ? state_q : ST_IDLE;
endmodule

// File: tb/tb_sopc_dbus_xbar.sv
// Directed bench for the data-side crossbar with hand-computed expectations.
module tb_sopc_dbus_xbar;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    int n_tests;
    int n_fail;

    sopc_dbus_xbar_if #(.NUM_SLV(4), .ADDR_W(32), .DATA_W(32)) bus ();

    sopc_dbus_xbar dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_ce_i    = 1'b0;
        bus.m_we_i    = 1'b0;
        bus.m_addr_i  = '0;
        bus.m_sel_i   = '0;
        bus.m_data_i  = '0;
        bus.s_ack_i   = '0;
        bus.err_clr_i = 1'b0;
    endtask

    // Counts ACCESS cycles; acks may be injected at cycle 0 and at cycle late_k.
    task automatic run_access(input logic [3:0] ack0, input int late_k,
                              input logic [3:0] late_ack, output int n);
        n = 0;
        for (int k = 0; k < 40; k++) begin
            bus.s_ack_i = (k == 0) ? ack0 : ((k == late_k) ? late_ack : 4'b0000);
            #2;
            if (dbg_state != 2'd1) break;
            n++;
            cyc();
        end
        bus.s_ack_i = '0;
    endtask

    // Read with ack in the first ACCESS cycle; starts in an IDLE cycle.
    task automatic read_imm(input logic [31:0] addr, input int slot,
                            input logic [31:0] dat, input string tg);
        bus.m_ce_i   = 1'b1;
        bus.m_we_i   = 1'b0;
        bus.m_addr_i = addr;
        bus.m_sel_i  = 4'hF;
        bus.s_data_i[slot*32 +: 32] = dat;
        #2;
        check_eq({tg, "_stall_T"}, 64'(bus.m_stall_o), 64'd1);
        check_eq({tg, "_sce_T"}, 64'(bus.s_ce_o), 64'd0);
        cyc();
        bus.s_ack_i = 4'(1 << slot);
        #2;
        check_eq({tg, "_sce_T1"}, 64'(bus.s_ce_o), 64'(4'(1 << slot)));
        check_eq({tg, "_stall_T1"}, 64'(bus.m_stall_o), 64'd1);
        check_eq({tg, "_saddr_T1"}, 64'(bus.s_addr_o), 64'(addr));
        cyc();
        bus.s_ack_i = '0;
        bus.m_ce_i  = 1'b0;
        #2;
        check_eq({tg, "_state_T2"}, 64'(dbg_state), 64'd2);
        check_eq({tg, "_stall_T2"}, 64'(bus.m_stall_o), 64'd0);
        check_eq({tg, "_data_T2"}, 64'(bus.m_data_o), 64'(dat));
        check_eq({tg, "_err_T2"}, 64'(bus.m_err_o), 64'd0);
        check_eq({tg, "_sce_T2"}, 64'(bus.s_ce_o), 64'd0);
        cyc();
        #2;
        check_eq({tg, "_data_T3"}, 64'(bus.m_data_o), 64'd0);
        check_eq({tg, "_state_T3"}, 64'(dbg_state), 64'd0);
    endtask

    initial begin
        int n;
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle_inputs();
        bus.s_data_i = '0;

        // Reset: outputs low while rst is held, even with a request pending.
        repeat (2) cyc();
        bus.m_ce_i = 1'b1;
        #2;
        check_eq("rst_stall", 64'(bus.m_stall_o), 64'd0);
        check_eq("rst_sce", 64'(bus.s_ce_o), 64'd0);
        check_eq("rst_data", 64'(bus.m_data_o), 64'd0);
        bus.m_ce_i = 1'b0;
        cyc();
        rst = 1'b0;
        #2;
        check_eq("rst_state", 64'(dbg_state), 64'd0);
        check_eq("rst_errint", 64'(bus.err_int_o), 64'd0);
        check_eq("rst_erraddr", 64'(bus.err_addr_o), 64'd0);
        check_eq("rst_swe", 64'(bus.s_we_o), 64'd0);

        // 1: read slave 0 with immediate ack
        cyc();
        read_imm(32'h0000_0010, 0, 32'hDEAD_BEEF, "t1");

        // 2: write slave 2, ack in the third ACCESS cycle
        bus.m_ce_i   = 1'b1;
        bus.m_we_i   = 1'b1;
        bus.m_addr_i = 32'h0800_0004;
        bus.m_sel_i  = 4'b0011;
        bus.m_data_i = 32'h1234_5678;
        bus.s_data_i[2*32 +: 32] = 32'hAAAA_5555;
        #2;
        check_eq("t2_stall_T", 64'(bus.m_stall_o), 64'd1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            bus.m_data_i = 32'hFFFF_FFFF;
            bus.m_sel_i  = 4'hF;
            bus.m_we_i   = 1'b0;
            bus.s_ack_i  = (c == 3) ? 4'b0100 : 4'b0000;
            #2;
            check_eq("t2_stall", 64'(bus.m_stall_o), 64'd1);
            check_eq("t2_sce", 64'(bus.s_ce_o), 64'b0100);
            check_eq("t2_swe", 64'(bus.s_we_o), 64'd1);
            check_eq("t2_ssel", 64'(bus.s_sel_o), 64'b0011);
            check_eq("t2_sdata", 64'(bus.s_data_o), 64'h1234_5678);
            check_eq("t2_saddr", 64'(bus.s_addr_o), 64'h0800_0004);
        end
        cyc();
        bus.s_ack_i = '0;
        bus.m_ce_i  = 1'b0;
        #2;
        check_eq("t2_done_state", 64'(dbg_state), 64'd2);
        check_eq("t2_done_stall", 64'(bus.m_stall_o), 64'd0);
        check_eq("t2_done_data", 64'(bus.m_data_o), 64'd0);
        check_eq("t2_done_err", 64'(bus.m_err_o), 64'd0);
        cyc();

        // 3: decode miss
        idle_inputs();
        bus.m_ce_i   = 1'b1;
        bus.m_addr_i = 32'hF000_0000;
        #2;
        check_eq("t3_stall_T", 64'(bus.m_stall_o), 64'd1);
        check_eq("t3_sce_T", 64'(bus.s_ce_o), 64'd0);
        cyc();
        bus.m_ce_i = 1'b0;
        #2;
        check_eq("t3_state_T1", 64'(dbg_state), 64'd2);
        check_eq("t3_err_T1", 64'(bus.m_err_o), 64'd1);
        check_eq("t3_stall_T1", 64'(bus.m_stall_o), 64'd0);
        check_eq("t3_sce_T1", 64'(bus.s_ce_o), 64'd0);
        check_eq("t3_errint_T1", 64'(bus.err_int_o), 64'd1);
        cyc();
        #2;
        check_eq("t3_err_T2", 64'(bus.m_err_o), 64'd0);
        check_eq("t3_errint_T2", 64'(bus.err_int_o), 64'd1);
        check_eq("t3_erraddr", 64'(bus.err_addr_o), 64'hF000_0000);
        bus.err_clr_i = 1'b1;
        cyc();
        bus.err_clr_i = 1'b0;
        #2;
        check_eq("t3_clr_errint", 64'(bus.err_int_o), 64'd0);
        check_eq("t3_clr_erraddr", 64'(bus.err_addr_o), 64'hF000_0000);

        // 4: timeout on slave 1
        cyc();
        bus.m_ce_i   = 1'b1;
        bus.m_addr_i = 32'h0400_0020;
        bus.s_data_i[1*32 +: 32] = 32'h1111_2222;
        cyc();
        bus.m_ce_i = 1'b0;
        run_access(4'b0000, -1, 4'b0000, n);
        check_eq("t4_access_cycles", 64'(n), 64'd16);
        check_eq("t4_done_state", 64'(dbg_state), 64'd2);
        check_eq("t4_done_err", 64'(bus.m_err_o), 64'd1);
        check_eq("t4_done_data", 64'(bus.m_data_o), 64'd0);
        check_eq("t4_erraddr", 64'(bus.err_addr_o), 64'h0400_0020);
        repeat (3) cyc();
        #2;
        check_eq("t4_errint_held", 64'(bus.err_int_o), 64'd1);
        // Second error with a clear in the same cycle: set wins.
        cyc();
        bus.m_ce_i    = 1'b1;
        bus.m_addr_i  = 32'hF800_0000;
        bus.err_clr_i = 1'b1;
        cyc();
        bus.m_ce_i    = 1'b0;
        bus.err_clr_i = 1'b0;
        #2;
        check_eq("t4_setwins_errint", 64'(bus.err_int_o), 64'd1);
        check_eq("t4_setwins_erraddr", 64'(bus.err_addr_o), 64'hF800_0000);
        cyc();
        bus.err_clr_i = 1'b1;
        cyc();
        bus.err_clr_i = 1'b0;
        #2;
        check_eq("t4_clr_errint", 64'(bus.err_int_o), 64'd0);

        // 5a/5b: foreign ack ignored; own ack in the timeout cycle wins
        cyc();
        bus.m_ce_i   = 1'b1;
        bus.m_addr_i = 32'h0400_0000;
        bus.s_data_i[1*32 +: 32] = 32'h5A5A_1234;
        bus.s_data_i[3*32 +: 32] = 32'h3333_3333;
        cyc();
        bus.m_ce_i = 1'b0;
        run_access(4'b1000, 15, 4'b0010, n);
        check_eq("t5_access_cycles", 64'(n), 64'd16);
        check_eq("t5_done_state", 64'(dbg_state), 64'd2);
        check_eq("t5_done_err", 64'(bus.m_err_o), 64'd0);
        check_eq("t5_done_data", 64'(bus.m_data_o), 64'h5A5A_1234);
        check_eq("t5_errint", 64'(bus.err_int_o), 64'd0);

        // 5c: back-to-back, second request presented during DONE
        cyc();
        bus.m_ce_i   = 1'b1;
        bus.m_addr_i = 32'h0000_0000;
        bus.s_data_i[0*32 +: 32] = 32'h0BAD_F00D;
        cyc();
        bus.s_ack_i = 4'b0001;
        cyc();
        bus.s_ack_i  = '0;
        bus.m_addr_i = 32'h1000_0008;
        bus.s_data_i[3*32 +: 32] = 32'hCAFE_F00D;
        #2;
        check_eq("t5c_done1_state", 64'(dbg_state), 64'd2);
        check_eq("t5c_done1_stall", 64'(bus.m_stall_o), 64'd0);
        check_eq("t5c_done1_data", 64'(bus.m_data_o), 64'h0BAD_F00D);
        cyc();
        #2;
        check_eq("t5c_idle_state", 64'(dbg_state), 64'd0);
        check_eq("t5c_idle_stall", 64'(bus.m_stall_o), 64'd1);
        cyc();
        bus.s_ack_i = 4'b1000;
        #2;
        check_eq("t5c_access_sce", 64'(bus.s_ce_o), 64'b1000);
        cyc();
        bus.s_ack_i = '0;
        bus.m_ce_i  = 1'b0;
        #2;
        check_eq("t5c_done2_data", 64'(bus.m_data_o), 64'hCAFE_F00D);

        // 6: reset in the second ACCESS cycle
        cyc();
        bus.m_ce_i   = 1'b1;
        bus.m_addr_i = 32'h0000_0040;
        cyc();
        bus.m_ce_i = 1'b0;
        #2;
        check_eq("t6_acc1_sce", 64'(bus.s_ce_o), 64'b0001);
        cyc();
        rst = 1'b1;
        #2;
        check_eq("t6_rst_stall", 64'(bus.m_stall_o), 64'd0);
        check_eq("t6_rst_sce", 64'(bus.s_ce_o), 64'd0);
        cyc();
        rst = 1'b0;
        bus.s_ack_i = 4'b0001;
        #2;
        check_eq("t6_post_state", 64'(dbg_state), 64'd0);
        check_eq("t6_post_sce", 64'(bus.s_ce_o), 64'd0);
        check_eq("t6_post_stall", 64'(bus.m_stall_o), 64'd0);
        check_eq("t6_post_saddr", 64'(bus.s_addr_o), 64'd0);
        cyc();
        #2;
        check_eq("t6_lateack_state", 64'(dbg_state), 64'd0);
        check_eq("t6_lateack_data", 64'(bus.m_data_o), 64'd0);
        bus.s_ack_i = '0;
        cyc();
        read_imm(32'h0000_0010, 0, 32'hDEAD_BEEF, "t6r");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
